tile_grid_renderer: RTL

TILE_GRID_RENDERER -- requirements
Module: tile_grid_renderer

---
 rtl/tile_grid_renderer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/tile_grid_renderer.sv
// Tile grid pixel renderer: maps x/y to a tile hit, local offset and a per-frame snapshot value.
// Optional TILE_FLASH_EN macro adds per-tile highlight counters that flash on value changes.
module tile_grid_renderer #(
   parameter int GRID_N       = 4,
   parameter int TILE_PX      = 99,
   parameter int GAP_PX       = 11,
   parameter int ORIGIN_X     = 25,
   parameter int ORIGIN_Y     = 25,
   parameter int VAL_W        = 12,
   parameter int FLASH_FRAMES = 8
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            frame_start,
   input  logic                            de,
   input  logic [9:0]                      x,
   input  logic [9:0]                      y,
   input  logic [GRID_N*GRID_N*VAL_W-1:0]  matrix_flat,
   output logic                            tile_active,
   output logic [2:0]                      tile_row,
   output logic [2:0]                      tile_col,
   output logic [9:0]                      local_x,
   output logic [9:0]                      local_y,
   output logic [VAL_W-1:0]                tile_value,
   output logic                            highlight
);

   localparam int PITCH = TILE_PX + GAP_PX;
   localparam int NT    = GRID_N * GRID_N;
   localparam int CW    = 12;

   function automatic logic [CW-1:0] tile_edge(input int origin, input int i);
      return CW'(origin + i * PITCH);
   endfunction

   logic [CW-1:0]       x_ext, y_ext;
   logic                col_hit, row_hit, hit;
   logic [2:0]          col_sel, row_sel;
   logic [9:0]          lx_sel, ly_sel;
   logic [5:0]          idx;
   logic [VAL_W-1:0]    val_sel;

   logic [NT*VAL_W-1:0] shadow_q, shadow_d;

   logic                s1_act_q, s1_act_d;
   logic [2:0]          s1_row_q, s1_row_d;
   logic [2:0]          s1_col_q, s1_col_d;
   logic [9:0]          s1_lx_q, s1_lx_d;
   logic [9:0]          s1_ly_q, s1_ly_d;
   logic [VAL_W-1:0]    s1_val_q, s1_val_d;

   logic                act_q, act_d;
   logic [2:0]          row_q, row_d;
   logic [2:0]          col_q, col_d;
   logic [9:0]          lx_q, lx_d;
   logic [9:0]          ly_q, ly_d;
   logic [VAL_W-1:0]    val_q, val_d;

`ifdef TILE_FLASH_EN
   logic [7:0]          cnt_q [NT];
   logic [7:0]          cnt_d [NT];
   logic [7:0]          cnt_sel;
   logic                s1_hl_q, s1_hl_d;
   logic                hl_q, hl_d;
`endif

   // Column and row decode are independent; a pixel hits only if both axes land inside a tile.
   always_comb begin
      x_ext   = {2'b00, x};
      y_ext   = {2'b00, y};
      col_hit = 1'b0;
      row_hit = 1'b0;
      col_sel = '0;
      row_sel = '0;
      lx_sel  = '0;
      ly_sel  = '0;
      for (int c = 0; c < GRID_N; c++) begin
         if (x_ext >= tile_edge(ORIGIN_X, c) &&
             x_ext <  tile_edge(ORIGIN_X, c) + CW'(TILE_PX)) begin
            col_hit = 1'b1;
            col_sel = 3'(c);
            lx_sel  = 10'(x_ext - tile_edge(ORIGIN_X, c));
         end
      end
      for (int r = 0; r < GRID_N; r++) begin
         if (y_ext >= tile_edge(ORIGIN_Y, r) &&
             y_ext <  tile_edge(ORIGIN_Y, r) + CW'(TILE_PX)) begin
            row_hit = 1'b1;
            row_sel = 3'(r);
            ly_sel  = 10'(y_ext - tile_edge(ORIGIN_Y, r));
         end
      end
      hit = de & col_hit & row_hit;
      idx = 6'(row_sel) * 6'(GRID_N) + 6'(col_sel);
   end

   // The shadow is read before the frame_start edge commits, so a pixel sampled together
   // with frame_start sees the old snapshot and the next pixel sees the new one.
   always_comb begin
      val_sel = '0;
      for (int i = 0; i < NT; i++) begin
         if (idx == 6'(i)) val_sel = shadow_q[i*VAL_W +: VAL_W];
      end
   end

`ifdef TILE_FLASH_EN
   always_comb begin
      cnt_sel = '0;
      for (int i = 0; i < NT; i++) begin
         if (idx == 6'(i)) cnt_sel = cnt_q[i];
      end
   end

   // Reload on a nonzero change wins over the per-frame decrement.
   always_comb begin
      for (int i = 0; i < NT; i++) begin
         cnt_d[i] = cnt_q[i];
         if (frame_start) begin
            if (matrix_flat[i*VAL_W +: VAL_W] != shadow_q[i*VAL_W +: VAL_W] &&
                matrix_flat[i*VAL_W +: VAL_W] != '0) begin
               cnt_d[i] = 8'(FLASH_FRAMES);
            end else if (cnt_q[i] != '0) begin
               cnt_d[i] = cnt_q[i] - 8'd1;
            end
         end
      end
   end
`endif

   always_comb begin
      shadow_d = frame_start ? matrix_flat : shadow_q;

      s1_act_d = hit;
      s1_row_d = hit ? row_sel : '0;
      s1_col_d = hit ? col_sel : '0;
      s1_lx_d  = hit ? lx_sel  : '0;
      s1_ly_d  = hit ? ly_sel  : '0;
      s1_val_d = hit ? val_sel : '0;

      act_d = s1_act_q;
      row_d = s1_row_q;
      col_d = s1_col_q;
      lx_d  = s1_lx_q;
      ly_d  = s1_ly_q;
      val_d = s1_val_q;
`ifdef TILE_FLASH_EN
      s1_hl_d = hit && (cnt_sel != '0);
      hl_d    = s1_hl_q;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
         s1_act_q <= 1'b0;
         s1_row_q <= '0;
         s1_col_q <= '0;
         s1_lx_q  <= '0;
         s1_ly_q  <= '0;
         s1_val_q <= '0;
         act_q    <= 1'b0;
         row_q    <= '0;
         col_q    <= '0;
         lx_q     <= '0;
         ly_q     <= '0;
         val_q    <= '0;
`ifdef TILE_FLASH_EN
         for (int i = 0; i < NT; i++) cnt_q[i] <= '0;
         s1_hl_q <= 1'b0;
         hl_q    <= 1'b0;
`endif
      end else begin
         shadow_q <= shadow_d;
         s1_act_q <= s1_act_d;
         s1_row_q <= s1_row_d;
         s1_col_q <= s1_col_d;
         s1_lx_q  <= s1_lx_d;
         s1_ly_q  <= s1_ly_d;
         s1_val_q <= s1_val_d;
         act_q    <= act_d;
         row_q    <= row_d;
         col_q    <= col_d;
         lx_q     <= lx_d;
         ly_q     <= ly_d;
         val_q    <= val_d;
`ifdef TILE_FLASH_EN
         for (int i = 0; i < NT; i++) cnt_q[i] <= cnt_d[i];
         s1_hl_q <= s1_hl_d;
         hl_q    <= hl_d;
`endif
      end
   end

   assign tile_active = act_q;
   assign tile_row    = row_q;
   assign tile_col    = col_q;
   assign local_x     = lx_q;
   assign local_y     = ly_q;
   assign tile_value  = val_q;
`ifdef TILE_FLASH_EN
   assign highlight   = hl_q;
`else
   assign highlight   = 1'b0;
`endif

endmodule
